// File: rtl/upmst_pkg.sv
// upmst_pkg -- shared definitions for the up-bus master.
// State encoding, default parameter values, timeout counter width and the
// read-data pattern returned on a timed-out access.
package upmst_pkg;

    // Master sequencer states (2-bit encoding).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STRB = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } upmst_state_t;

    // Default widths and timeout.
    localparam int AW_DEF   = 16;
    localparam int DW_DEF   = 8;
    localparam int TOUT_DEF = 255;

    // Wide enough for the largest legal TOUT (65535).
    localparam int CNT_W = 16;

    // Every bit of rsp_rdat takes this value on a timeout response.
    localparam logic TO_RDAT_BIT = 1'b1;

    // Counter value at which the last allowed wait cycle is reached.
    function automatic logic [CNT_W-1:0] tout_last(input int tout);
        return CNT_W'(tout - 1);
    endfunction

endpackage

// File: rtl/upmst_tocnt.sv
// upmst_tocnt -- wait-cycle counter for the up-bus master timeout.
// Cleared while the strobe is out, counts each wait cycle, and flags the
// cycle in which the count reaches TOUT-1 (the final cycle allowed for an
// acknowledge). Only instantiated when UPMST_TIMEOUT_EN is defined.
module upmst_tocnt
    import upmst_pkg::*;
#(
    parameter int TOUT = TOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic hit
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // Clear has priority over increment; otherwise hold.
    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (inc) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign hit = (cnt_reg == tout_last(TOUT));

endmodule

// File: rtl/upmst.sv
// upmst -- up-bus master.
// Accepts one host command at a time, issues a single-cycle strobe to the
// slaves, waits for the OR-combined acknowledge and returns a one-cycle
// response pulse with captured read data.
// Optional feature: define UPMST_TIMEOUT_EN to abandon an access after TOUT
// wait cycles without acknowledge (rsp_err=1, rsp_rdat all-ones). Without it
// the master waits indefinitely and rsp_err is constant 0.
module upmst
    import upmst_pkg::*;
#(
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF,
    parameter int TOUT = TOUT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    // host command side
    input  logic          cmd_vld,
    output logic          cmd_rdy,
    input  logic          cmd_wr,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdat,
    // host response side
    output logic          rsp_vld,
    output logic [DW-1:0] rsp_rdat,
    output logic          rsp_err,
    // up-bus
    output logic          upact,
    output logic          upen,
    output logic          upws,
    output logic          uprs,
    output logic [AW-1:0] upa,
    output logic [DW-1:0] updi,
    input  logic [DW-1:0] updo,
    input  logic          upack
);

    upmst_state_t  state_reg;
    upmst_state_t  state_next;

    logic          upact_reg;
    logic          wr_reg;
    logic [AW-1:0] upa_reg;
    logic [DW-1:0] updi_reg;
    logic [DW-1:0] rsp_rdat_reg;

    logic          cmd_accept;
    logic          cap_ack;
    logic [DW-1:0] wdat_masked;
    logic [DW-1:0] rdat_masked;

`ifdef UPMST_TIMEOUT_EN
    logic          rsp_err_reg;
    logic          cap_to;
    logic          tc_clr;
    logic          tc_inc;
    logic          to_hit;

    upmst_tocnt #(
        .TOUT (TOUT)
    ) u_tocnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tc_clr),
        .inc   (tc_inc),
        .hit   (to_hit)
    );
`endif

    // upact_reg doubles as the "out of reset" flag so cmd_rdy stays low
    // throughout reset and rises in the first cycle after release.
    assign cmd_rdy    = (state_reg == IDLE) && upact_reg;
    assign cmd_accept = cmd_vld && cmd_rdy;

    // Reads drive zero write data; writes capture zero read data.
    genvar gi;
    generate
        for (gi = 0; gi < DW; gi++) begin : g_mask
            assign wdat_masked[gi] = cmd_wdat[gi] & cmd_wr;
            assign rdat_masked[gi] = updo[gi] & ~wr_reg;
        end
    endgenerate

    // Next-state logic; acknowledge is only looked at in STRB and WAIT.
    always_comb begin
        state_next = state_reg;
        cap_ack    = 1'b0;
`ifdef UPMST_TIMEOUT_EN
        cap_to     = 1'b0;
        tc_clr     = 1'b0;
        tc_inc     = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (cmd_accept) begin
                    state_next = STRB;
                end
            end
            STRB: begin
`ifdef UPMST_TIMEOUT_EN
                tc_clr = 1'b1;
`endif
                if (upack) begin
                    cap_ack    = 1'b1;
                    state_next = RESP;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
`ifdef UPMST_TIMEOUT_EN
                tc_inc = 1'b1;
`endif
                if (upack) begin
                    // An acknowledge in the final allowed cycle still wins.
                    cap_ack    = 1'b1;
                    state_next = RESP;
`ifdef UPMST_TIMEOUT_EN
                end else if (to_hit) begin
                    cap_to     = 1'b1;
                    state_next = RESP;
`endif
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; reset abandons any access without a response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            upact_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            upact_reg <= 1'b1;
        end
    end

    // Command capture: address, write data and direction held until next accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_reg   <= 1'b0;
            upa_reg  <= '0;
            updi_reg <= '0;
        end else if (cmd_accept) begin
            wr_reg   <= cmd_wr;
            upa_reg  <= cmd_addr;
            updi_reg <= wdat_masked;
        end
    end

    // Response data capture; held until the next response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_rdat_reg <= '0;
        end else if (cap_ack) begin
            rsp_rdat_reg <= rdat_masked;
`ifdef UPMST_TIMEOUT_EN
        end else if (cap_to) begin
            rsp_rdat_reg <= {DW{TO_RDAT_BIT}};
`endif
        end
    end

`ifdef UPMST_TIMEOUT_EN
    // Error flag: set by a timeout, cleared by a real acknowledge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_err_reg <= 1'b0;
        end else if (cap_ack) begin
            rsp_err_reg <= 1'b0;
        end else if (cap_to) begin
            rsp_err_reg <= 1'b1;
        end
    end

    assign rsp_err = rsp_err_reg;
`else
    assign rsp_err = 1'b0;
`endif

    // Strobes decode straight from the state register, so they last exactly
    // the single STRB cycle and write/read strobes are mutually exclusive.
    assign upen     = (state_reg == STRB);
    assign upws     = upen && wr_reg;
    assign uprs     = upen && !wr_reg;
    assign upact    = upact_reg;
    assign upa      = upa_reg;
    assign updi     = updi_reg;
    assign rsp_vld  = (state_reg == RESP);
    assign rsp_rdat = rsp_rdat_reg;

endmodule

// File: tb/tb_upmst.sv
// tb_upmst -- self-checking bench for upmst.
// A transaction-level model predicts, per accepted command, the strobe cycle,
// the response cycle and the response data from the slave latency; a single
// compare process checks the DUT against it every cycle. The slave is an
// XOR-latch ("stickyx") responder with per-access latency (-1 = never ack).
module tb_upmst;

    localparam int AW   = 16;
    localparam int DW   = 8;
    localparam int TOUT = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_vld = 1'b0;
    logic          cmd_rdy;
    logic          cmd_wr = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdat = '0;
    logic          rsp_vld;
    logic [DW-1:0] rsp_rdat;
    logic          rsp_err;
    logic          upact;
    logic          upen;
    logic          upws;
    logic          uprs;
    logic [AW-1:0] upa;
    logic [DW-1:0] updi;
    logic [DW-1:0] updo = '0;
    logic          upack = 1'b0;

    always #5 clk = ~clk;

    upmst #(
        .AW   (AW),
        .DW   (DW),
        .TOUT (TOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_vld  (cmd_vld),
        .cmd_rdy  (cmd_rdy),
        .cmd_wr   (cmd_wr),
        .cmd_addr (cmd_addr),
        .cmd_wdat (cmd_wdat),
        .rsp_vld  (rsp_vld),
        .rsp_rdat (rsp_rdat),
        .rsp_err  (rsp_err),
        .upact    (upact),
        .upen     (upen),
        .upws     (upws),
        .uprs     (uprs),
        .upa      (upa),
        .updi     (updi),
        .updo     (updo),
        .upack    (upack)
    );

    typedef struct {
        int            acc;
        int            rsp;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdat;
        logic [DW-1:0] rdat;
        bit            err;
    } txn_t;

    txn_t exq[$];
    int   slq[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit dut_rst = 1'b1;
    bit chk_en  = 1'b0;

    logic [DW-1:0] m_latch = 8'hF0;
    logic [DW-1:0] latch   = 8'hF0;
    bit            s_pend  = 1'b0;
    int            s_age   = 0;
    int            s_lat   = 0;
    bit            s_wr    = 1'b0;
    bit            inj_ack = 1'b0;

    logic [DW-1:0] last_rdat = '0;
    logic          last_err  = 1'b0;
    int            last_rsp  = 0;
    int            last_acc  = 0;
    int            rsp_cnt   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        dut_rst <= !rst_n;
    end

    // Slave: XOR-latch on write strobe, acks after its latency, random updo otherwise.
    always @(negedge clk) begin
        upack = 1'b0;
        updo  = DW'($urandom);
        if (upen) begin
            s_pend = 1'b1;
            s_age  = 0;
            s_wr   = upws;
            s_lat  = (slq.size() != 0) ? slq.pop_front() : 0;
            if (upws) latch = latch ^ updi;
        end else if (s_pend) begin
            s_age++;
        end
        if (s_pend && s_lat >= 0 && s_age == s_lat) begin
            upack  = 1'b1;
            if (!s_wr) updo = latch;
            s_pend = 1'b0;
        end
        if (inj_ack) upack = 1'b1;
    end

    // Per-cycle comparison against the transaction model.
    always @(negedge clk) begin
        if (chk_en) begin
            bit   have;
            bit   busy;
            bit   exp_stb;
            bit   exp_vld;
            txn_t t;
            have = (exq.size() != 0);
            if (have) t = exq[0];
            busy    = have && (cyc > t.acc) && (cyc <= t.rsp);
            exp_stb = have && (cyc == t.acc + 1);
            exp_vld = have && (cyc == t.rsp);
            chk("rsp_vld", rsp_vld, exp_vld);
            chk("cmd_rdy", cmd_rdy, !dut_rst && !busy);
            chk("upact",   upact,   !dut_rst);
            chk("upen",    upen,    exp_stb);
            chk("upws",    upws,    exp_stb && t.wr);
            chk("uprs",    uprs,    exp_stb && !t.wr);
            if (busy) begin
                chk("upa_hold",  upa,  t.addr);
                chk("updi_hold", updi, t.wr ? t.wdat : '0);
            end
            if (rsp_vld) begin
                rsp_cnt++;
                last_rsp  = cyc;
                last_rdat = rsp_rdat;
                last_err  = rsp_err;
            end
            if (exp_vld) begin
                chk("rsp_rdat", rsp_rdat, t.rdat);
                chk("rsp_err",  rsp_err,  t.err);
                $display("txn acc=%0d rsp=%0d wr=%0d addr=%h wdat=%h rdat=%h err=%0d",
                         t.acc, cyc, t.wr, t.addr, t.wdat, rsp_rdat, rsp_err);
                void'(exq.pop_front());
            end
        end
    end

    // Present a command, wait for acceptance, record the model's prediction.
    task automatic issue(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdat,
                         input int lat, input bit keep);
        txn_t t;
        int   n;
        bit   to;
        cmd_vld  = 1'b1;
        cmd_wr   = wr;
        cmd_addr = addr;
        cmd_wdat = wdat;
        n = 0;
        @(negedge clk);
        while (!cmd_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", cmd_rdy, 1'b1);
        if (!cmd_rdy) begin
            cmd_vld = 1'b0;
            return;
        end
`ifdef UPMST_TIMEOUT_EN
        to = (lat < 0) || (lat > TOUT);
`else
        to = 1'b0;
`endif
        t.acc  = cyc;
        t.rsp  = cyc + 2 + (to ? TOUT : lat);
        t.wr   = wr;
        t.addr = addr;
        t.wdat = wdat;
        t.err  = to;
        t.rdat = to ? {DW{1'b1}} : (wr ? '0 : m_latch);
        if (wr) m_latch = m_latch ^ wdat;
        last_acc = cyc;
        exq.push_back(t);
        slq.push_back(lat);
        @(posedge clk);
        #1;
        if (!keep) cmd_vld = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exq.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        chk("done_wait", exq.size() == 0, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a0;
        int a1;
        int a2;
        int rc0;
        int lat;
        int r;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_cmd_rdy", cmd_rdy, 1'b0);
        chk("rst_upa", upa, '0);
        chk("rst_rdat", rsp_rdat, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rdy_after_rst", cmd_rdy, 1'b1);

        // Write 0x30 into latch 0xF0 through a registered slave.
        issue(1'b1, 16'h1234, 8'h30, 1, 1'b0);
        wait_done();
        chk("wr_latency", last_rsp - last_acc, 3);
        chk("wr_err", last_err, 1'b0);
        chk("wr_latch", latch, 8'hC0);

        // Read it back.
        issue(1'b0, 16'h1234, 8'h77, 1, 1'b0);
        wait_done();
        chk("rd_latency", last_rsp - last_acc, 3);
        chk("rd_rdat", last_rdat, 8'hC0);
        chk("rd_err", last_err, 1'b0);

        // Combinational slave.
        issue(1'b0, 16'h0042, 8'h00, 0, 1'b0);
        wait_done();
        chk("comb_latency", last_rsp - last_acc, 2);
        chk("comb_rdat", last_rdat, 8'hC0);

        // Back-to-back with cmd_vld held high.
        rc0 = rsp_cnt;
        issue(1'b1, 16'h0100, 8'h0F, 1, 1'b1);
        a0 = last_acc;
        issue(1'b0, 16'h0101, 8'h00, 1, 1'b1);
        a1 = last_acc;
        issue(1'b1, 16'h0102, 8'hA5, 1, 1'b0);
        a2 = last_acc;
        wait_done();
        chk("b2b_gap1", a1 - a0, 4);
        chk("b2b_gap2", a2 - a1, 4);
        chk("b2b_pulses", rsp_cnt - rc0, 3);

`ifdef UPMST_TIMEOUT_EN
        // Timeout with no ack, then a stray late ack.
        issue(1'b0, 16'h0DEF, 8'h00, -1, 1'b0);
        wait_done();
        chk("to_latency", last_rsp - last_acc, 2 + TOUT);
        chk("to_err", last_err, 1'b1);
        chk("to_rdat", last_rdat, 8'hFF);
        rc0 = rsp_cnt;
        inj_ack = 1'b1;
        @(posedge clk);
        #1;
        inj_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("late_ack_rdy", cmd_rdy, 1'b1);
        chk("late_ack_norsp", rsp_cnt - rc0, 0);

        // Ack exactly in the timeout cycle wins.
        latch   = 8'h5A;
        m_latch = 8'h5A;
        issue(1'b0, 16'h0ACE, 8'h00, TOUT, 1'b0);
        wait_done();
        chk("edge_err", last_err, 1'b0);
        chk("edge_rdat", last_rdat, 8'h5A);
`endif

        // Reset while waiting for an ack.
`ifdef UPMST_TIMEOUT_EN
        lat = -1;
`else
        lat = 20;
`endif
        rc0 = rsp_cnt;
        issue(1'b0, 16'h0BAD, 8'h00, lat, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exq.delete();
        slq.delete();
        s_pend = 1'b0;
        chk("mrst_upen", upen, 1'b0);
        chk("mrst_upa", upa, '0);
        chk("mrst_updi", updi, '0);
        chk("mrst_rdat", rsp_rdat, '0);
        chk("mrst_err", rsp_err, 1'b0);
        chk("mrst_upact", upact, 1'b0);
        chk("mrst_rdy", cmd_rdy, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_rdy_after", cmd_rdy, 1'b1);
        chk("mrst_norsp", rsp_cnt - rc0, 0);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
`ifdef UPMST_TIMEOUT_EN
            r   = int'($urandom_range(0, 8));
            lat = (r <= TOUT + 2) ? r : -1;
`else
            lat = int'($urandom_range(0, 6));
`endif
            issue(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), lat,
                  1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                cmd_vld = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        cmd_vld = 1'b0;
        wait_done();
        chk("final_latch", latch, m_latch);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/upmst.md
UPMST -- requirements
Module: upmst

Interface
REQ-001 The block SHALL have parameter AW, default 16, the width of the up-bus address.
REQ-002 The block SHALL have parameter DW, default 8, the width of the up-bus data.
REQ-003 The block SHALL have parameter TOUT, default 255, the number of cycles the master waits for upack before giving up; legal range 1..65535.
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all logic on rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have port cmd_vld, input, 1 bit: host command valid.
REQ-007 The block SHALL have port cmd_rdy, output, 1 bit: master idle and able to accept a command.
REQ-008 The block SHALL have port cmd_wr, input, 1 bit: 1 means write, 0 means read.
REQ-009 The block SHALL have port cmd_addr, input, AW bits: access address.
REQ-010 The block SHALL have port cmd_wdat, input, DW bits: write data.
REQ-011 The block SHALL have port rsp_vld, output, 1 bit: one-cycle response pulse.
REQ-012 The block SHALL have port rsp_rdat, output, DW bits: read data, valid with rsp_vld.
REQ-013 The block SHALL have port rsp_err, output, 1 bit: timeout flag, valid with rsp_vld.
REQ-014 The block SHALL have port upact, output, 1 bit: bus active level; 0 in reset, 1 otherwise.
REQ-015 The block SHALL have ports upen, upws and uprs, outputs, 1 bit each: slave enable, write strobe and read strobe.
REQ-016 The block SHALL have port upa, output, AW bits: address.
REQ-017 The block SHALL have port updi, output, DW bits: write data to the slave.
REQ-018 The block SHALL have port updo, input, DW bits: OR-combined slave read data.
REQ-019 The block SHALL have port upack, input, 1 bit: OR-combined slave acknowledge.

Function
REQ-020 The state machine SHALL have states IDLE, STRB, WAIT and RESP, with cmd_rdy = (state == IDLE).
REQ-021 A command SHALL be accepted in cycle N when cmd_vld & cmd_rdy, and the next state SHALL be STRB.
REQ-022 On acceptance, upa, updi and the direction SHALL be registered, and updi SHALL be 0 for reads.
REQ-023 upen, and upws (write) or uprs (read), SHALL be high only in STRB, for exactly one cycle (N+1); upws and uprs SHALL never be high together.
REQ-024 upa and updi SHALL hold their values from STRB until the RESP cycle inclusive.
REQ-025 upack SHALL be sampled in STRB and in WAIT; upack high SHALL capture updo into rsp_rdat (reads; writes capture 0), clear rsp_err and move to RESP.
REQ-026 STRB without upack SHALL move to WAIT.
REQ-027 A registered slave (ack in N+2) SHALL yield rsp_vld in cycle N+3; a combinational slave (ack in N+1) SHALL yield rsp_vld in cycle N+2.
REQ-028 RESP SHALL assert rsp_vld for one cycle and then return to IDLE; a new command SHALL be acceptable in the cycle after RESP.
REQ-029 rsp_rdat and rsp_err SHALL hold their values until the next response.
REQ-030 upack in IDLE or RESP, including a late ack after a timeout, SHALL be ignored.

Reset
REQ-031 rst_n low SHALL force state IDLE.
REQ-032 rst_n low SHALL force upen, upws, uprs, upact, rsp_vld and rsp_err to 0, and upa, updi and rsp_rdat to all-zero.
REQ-033 rst_n low SHALL clear the timeout counter.
REQ-034 Reset mid-access SHALL abort the access silently, with no rsp_vld.
REQ-035 cmd_rdy SHALL be 0 during reset and 1 in the first cycle after reset.

Configuration
REQ-036 With macro UPMST_TIMEOUT_EN defined, a counter SHALL clear in STRB and increment each WAIT cycle.
REQ-037 With UPMST_TIMEOUT_EN defined, when the counter equals TOUT-1 in WAIT and upack is low, the next state SHALL be RESP with rsp_err=1 and rsp_rdat all-ones.
REQ-038 With UPMST_TIMEOUT_EN defined, upack high in the timeout cycle SHALL win, giving a normal response.
REQ-039 Without UPMST_TIMEOUT_EN, no counter SHALL exist, WAIT SHALL persist until upack, rsp_err SHALL be tied 0, and TOUT SHALL be unused.

Structure
REQ-040 Shared package upmst_pkg SHALL hold the state encoding constants (2-bit: IDLE=0, STRB=1, WAIT=2, RESP=3), the default AW/DW/TOUT values, and the timeout read pattern.
REQ-041 The timeout counter SHALL be sub-module upmst_tocnt (inputs clk, rst_n, clr, inc; output hit), instantiated only under UPMST_TIMEOUT_EN.

Verification
REQ-042 Write with stickyx slave (DW=8, upact=1, latch=0xF0): cmd_wr=1, wdat=0x30 -> upen/upws one cycle, rsp_vld at N+3, rsp_err=0, slave latch=0xC0.
REQ-043 Read of the same slave -> uprs one cycle, rsp_rdat=0xC0 at N+3, rsp_err=0, updi=0 during strobe.
REQ-044 Back-to-back: cmd_vld held high with 3 commands -> accepts spaced 4 cycles apart, exactly 3 rsp_vld pulses, no overlapping strobes.
REQ-045 Timeout (macro on, TOUT=4), no slave ack -> rsp_vld with rsp_err=1 and rsp_rdat=0xFF; upack injected 2 cycles later is ignored and cmd_rdy stays 1.
REQ-046 Ack in the timeout cycle (TOUT=4), updo=0x5A -> rsp_err=0, rsp_rdat=0x5A.
REQ-047 rst_n low during WAIT -> no rsp_vld, all outputs at reset values next cycle, cmd_rdy=1 after release.
